// File: rtl/alu_md_seq.sv
// Registered base-op ALU plus iterative RV32M-style multiply/divide unit.
// A single valid/ready handshake; base ops finish in 1 cycle, M ops in WIDTH+1.
module alu_md_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             ALT,
  input  logic             MEXT,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             SIGN,
  output logic             SLTU
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [2:0]         op;
  logic               neg_hi;
  logic               neg_rem;
  logic               sltu_q;

  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   base_res;
  logic               a_sg;
  logic               b_sg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_hi_d;
  logic               neg_rem_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   m_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = DATA2[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (SELECT)
      3'd0: base_res = ALT ? (DATA1 - DATA2) : (DATA1 + DATA2);
      3'd1: base_res = DATA1 << shamt;
      3'd2: base_res = WIDTH'($signed(DATA1) < $signed(DATA2));
      3'd3: base_res = WIDTH'(DATA1 < DATA2);
      3'd4: base_res = DATA1 ^ DATA2;
      3'd5: base_res = ALT ? WIDTH'($signed(DATA1) >>> shamt) : (DATA1 >> shamt);
      3'd6: base_res = DATA1 | DATA2;
      3'd7: base_res = DATA1 & DATA2;
      default: base_res = '0;
    endcase
  end

  // Operand signedness: MULH/MULHSU sign rs1, MULH signs rs2; DIV/REM sign both.
  always_comb begin
    a_sg      = SELECT[2] ? ~SELECT[0] : (SELECT == 3'd1 || SELECT == 3'd2);
    b_sg      = SELECT[2] ? ~SELECT[0] : (SELECT == 3'd1);
    a_mag     = (a_sg && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
    b_mag     = (b_sg && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
    // Divide by zero keeps the all-ones quotient unsigned; product is zero anyway.
    neg_hi_d  = ((a_sg && DATA1[WIDTH-1]) ^ (b_sg && DATA2[WIDTH-1])) && (DATA2 != '0);
    neg_rem_d = a_sg && DATA1[WIDTH-1];
  end

  // acc holds {hi, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = ~div_diff[WIDTH];
    if (op[2])
      acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    prod_fix = neg_hi ? -acc_next : acc_next;
    quot_fix = neg_hi ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    m_res    = '0;
    case (op)
      3'd0:                m_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    m_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          m_res = quot_fix;
      default:             m_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      op      <= '0;
      neg_hi  <= 1'b0;
      neg_rem <= 1'b0;
      sltu_q  <= 1'b0;
      RESULT  <= '0;
      ZERO    <= 1'b0;
      SIGN    <= 1'b0;
      SLTU    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sltu_q <= (DATA1 < DATA2);
            if (MEXT) begin
              state   <= CALC;
              cnt     <= CW'(WIDTH);
              op      <= SELECT;
              neg_hi  <= neg_hi_d;
              neg_rem <= neg_rem_d;
              acc     <= {{WIDTH{1'b0}}, (SELECT[2] ? a_mag : b_mag)};
              opb     <= SELECT[2] ? b_mag : a_mag;
            end else begin
              state  <= DONE;
              RESULT <= base_res;
              ZERO   <= (base_res == '0);
              SIGN   <= base_res[WIDTH-1];
              SLTU   <= (DATA1 < DATA2);
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          // Last iteration and sign fix-up resolve in the same edge.
          if (cnt == CW'(1)) begin
            state  <= DONE;
            RESULT <= m_res;
            ZERO   <= (m_res == '0);
            SIGN   <= m_res[WIDTH-1];
            SLTU   <= sltu_q;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
- Parametrised successor to the processor's combinational integer ALU: registered base-op ALU plus an iterative RV32M-style multiply/divide unit behind one valid/ready handshake.
- Sits in the EX stage. The pipeline stalls on in_ready/out_valid instead of assuming single-cycle results.
- Adds what the current ALU lacks: SUB, masked shift amounts, MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, width generality and registered flags.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), derived localparam; number of shift-amount bits used from DATA2.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation this cycle.
- DATA1  input  WIDTH  operand 1 (rs1).
- DATA2  input  WIDTH  operand 2 (rs2 / immediate).
- SELECT  input  3  funct3-style operation code.
- ALT  input  1  SUB when SELECT=0, SRA when SELECT=5; ignored otherwise and when MEXT=1.
- MEXT  input  1  1 selects the mul/div group.
- out_valid  output  1  RESULT and flags are valid.
- out_ready  input  1  consumer takes the result.
- RESULT  output  WIDTH  registered result.
- ZERO  output  1  RESULT == 0.
- SIGN  output  1  RESULT[WIDTH-1].
- SLTU  output  1  unsigned DATA1 < DATA2 of the accepted operation.

Behaviour:
- Accept: an operation is accepted when in_valid && in_ready. in_ready = (state==IDLE). Operands and opcode are latched on accept; inputs are don't-care afterwards.
- States:
  - IDLE -> DONE on accepting a base op (MEXT=0).
  - IDLE -> CALC on accepting an M op (MEXT=1); load counter = WIDTH.
  - CALC: one iteration per cycle, counter decrements; when counter==1 the state goes to DONE at the next edge.
  - DONE: out_valid=1; RESULT and flags are held stable until out_ready=1, then -> IDLE. No accept in DONE.
- Latency: base op out_valid in cycle T+1 after accept cycle T; M op out_valid in cycle T+WIDTH+1. The latency is fixed and independent of operand values.
- Base ops (MEXT=0):
  - 0: ADD, or SUB if ALT.
  - 1: SLL.
  - 2: SLT, signed.
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL, or SRA if ALT.
  - 6: OR.
  - 7: AND.
  - Shift amount = DATA2[SHW-1:0]; upper bits are ignored.
  - Add/sub wrap modulo 2^WIDTH.
  - SLT/SLTU give 1 or 0, zero-extended.
- M ops (MEXT=1):
  - 0: MUL, low WIDTH bits.
  - 1: MULH, signed x signed, high half.
  - 2: MULHSU, signed x unsigned, high half.
  - 3: MULHU, high half.
  - 4: DIV, signed, truncates toward zero.
  - 5: DIVU.
  - 6: REM, signed; sign follows the dividend.
  - 7: REMU.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator; negate the product at the end if operand signs differ (per signedness of the op).
  - Divide: restoring, one quotient bit per cycle on magnitudes; fix quotient and remainder signs at the end.
- Boundary cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = DATA1.
  - Signed overflow (DATA1 = most-negative, DATA2 = -1): DIV = most-negative, REM = 0.
  - Both boundary cases still take the full WIDTH+1 latency.
- Flags: ZERO, SIGN and SLTU are registered together with RESULT and valid whenever out_valid=1.
- Reset: RESET=1 at any edge, including mid-CALC or in DONE, forces:
  - state IDLE, counter 0;
  - out_valid=0;
  - RESULT=0, ZERO=0, SIGN=0, SLTU=0;
  - in_ready=1 in the cycle after reset deasserts.
  - An in-flight operation is discarded, never delivered.
- in_valid while busy: ignored (not accepted, not queued). The producer must hold it until in_ready.

Test Plan:
- Reset/idle: RESET=1 for 2 cycles -> out_valid=0, RESULT=0, ZERO=0, in_ready=1 after release.
- Base ops:
  - SELECT=0, ALT=1, 5-7 -> RESULT=0xFFFFFFFE, SIGN=1, out_valid at T+1.
  - SELECT=5, ALT=1, DATA1=0x80000000, DATA2=0x24 (shift 4) -> 0xF8000000.
  - SELECT=2 with -1 vs 1 -> 1; SELECT=3 with the same operands -> 0, SLTU=0.
- Multiply:
  - MEXT=1, SELECT=1, 0xFFFFFFFF x 0xFFFFFFFF -> 0.
  - SELECT=3 on the same operands -> 0xFFFFFFFE.
  - SELECT=0, 7x6 -> 42.
  - out_valid exactly at T+33; in_ready=0 during T+1..T+33.
- Divide boundary cases:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/-1 -> 0x80000000; REM on the same operands -> 0, ZERO=1.
- Backpressure/reset: hold out_ready=0 for 5 cycles in DONE -> RESULT and flags stable, no new accept. Assert RESET at cycle 10 of a DIV -> no out_valid; a following ADD 1+1 returns 2 at T+1.
